vga_scene_sequencer: RTL and testbench
======================================

# vga_scene_sequencer

Frame-synchronous controller that sequences the VGA pattern datapath. It watches the sync generator's vsync and, once per frame, updates the scroll offsets, pattern mode and blanking that the pixel pattern logic consumes. Scenes advance on a frame timer or a debounced push-button, with a pause/single-step mode. It sits between the hvsync generator and the RGB pattern logic, and everything runs in the single pixel-clock domain; no logic is clocked by vsync.

## Interface
Parameters:
- FRAMES_PER_SCENE, 256: frame ticks per scene before an automatic advance (≥2).
- BLANK_FRAMES, 2: frames of forced blanking between scenes (≥1).
- DEBOUNCE_CYCLES, 65536: consecutive stable clk cycles needed to accept a button level (≥2).
- VSYNC_ACTIVE, 0: active level of `vsync` (0 = active-low).

Ports:
- clk  in  1  pixel clock; the only clock.
- rst_n  in  1  reset, asynchronous and active-low.
- vsync  in  1  from hvsync generator, same clock domain.
- btn_next  in  1  raw, asynchronous push-button; advances the scene.
- btn_pause  in  1  raw, asynchronous push-button; toggles pause.
- speed  in  2  scroll step select: 0→1, 1→2, 2→4, 3→8 pixels/frame; sampled at the frame tick.
- dir  in  1  scroll direction: 0 = add, 1 = subtract; sampled at the frame tick.
- scroll_x  out  10  horizontal offset, subtracted from pix_x by the pattern logic.
- scroll_y  out  10  vertical offset.
- mode  out  2  pattern select.
- blank  out  1  forces RGB to 0 when high.
- paused  out  1  high in PAUSE state.
- frame_tick  out  1  one-cycle pulse per frame.

## Operation
- Tick detection: `vsync_d` registers `vsync`. The internal tick is true on a clock edge where `vsync` is sampled at VSYNC_ACTIVE and `vsync_d` is not. `frame_tick` is that tick registered. Every state and output update below happens on that same edge.
- Buttons: each button passes through a 2-flop synchronizer and then a debounce counter. The debounced level changes only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
- Pending flags: a debounced rising edge sets a sticky pending flag (`next_p` or `pause_p`). Multiple presses within one frame collapse into one action. A flag clears only when consumed at a tick.
- Step arithmetic: step = 1<<speed. Both scroll registers are 10-bit modulo 1024 and wrap silently in both directions.
- **RUN** state, at each tick, in priority order:
  1. `pause_p` → go to PAUSE and clear `pause_p`; `next_p` stays pending.
  2. Else if `next_p` set, or timer == FRAMES_PER_SCENE-1 → go to BLANK. Set blank=1, timer=0, bcnt=0, clear `next_p`. Scroll is not updated on this tick.
  3. Else timer+1. scroll_x ± step. scroll_y+1 when mode ≥ 2; otherwise scroll_y is held.
- **BLANK** state, at each tick:
  - If bcnt == BLANK_FRAMES-1: mode ← mode+1 (3 wraps to 0), scroll_x = scroll_y = 0, timer = 0, blank = 0, go to RUN.
  - Else bcnt+1.
  - `next_p` is cleared (discarded) on every BLANK tick. `pause_p` is kept and serviced in RUN.
- **PAUSE** state, at each tick:
  - `pause_p` → go to RUN, clear the flag. Timer and scroll resume from their held values.
  - Else if `next_p` → single step: mode+1, scroll_x = scroll_y = 0, timer = 0, clear the flag, stay in PAUSE.
  - Otherwise everything is held. blank = 0 throughout PAUSE.
- `paused` is 1 exactly when the state is PAUSE.

## Timing
- Reset values: state RUN, scroll_x = scroll_y = 0, mode = 0, blank = 0, paused = 0, frame_tick = 0. Timer, bcnt, `vsync_d`, synchronizers, debounced levels and pending flags are all 0.
- Reset acts immediately on assertion, including mid-BLANK or mid-debounce. First tick after release requires a fresh inactive→active vsync transition.
- Output latency: outputs change on the edge that sees the vsync transition. frame_tick is high for exactly the following cycle.
- Vsync held active for any number of cycles → exactly one tick.
- Button-to-action latency: 2 sync cycles + DEBOUNCE_CYCLES, then the next tick.
- `speed` and `dir` are only sampled at ticks; changes between ticks have no effect until then.

## Test plan
Benches use FRAMES_PER_SCENE=4, BLANK_FRAMES=2, DEBOUNCE_CYCLES=4, VSYNC_ACTIVE=0.
- Auto advance: reset, speed=1, dir=0, 6 vsync pulses → ticks 1–3: scroll_x 2,4,6. Tick 4: blank=1, scroll_x stays 6. Tick 5: blank=1. Tick 6: blank=0, mode=1, scroll_x=0.
- Wrap: dir=1, speed=3 from 0 → scroll_x 1016, then 1008. In mode 2, scroll_y counts 1,2,…; 1023 wraps to 0.
- Debounce: btn_next glitch of 3 cycles → no effect. Held 10 cycles → next tick enters BLANK (blank=1) with timer=0; a second press during BLANK is discarded.
- Pause/step: press btn_pause → next tick paused=1, scroll frozen across 3 ticks. Press btn_next → mode+1, scroll=0, paused=1. Press btn_pause → RUN, scroll resumes at step per tick.
- Simultaneous: both buttons pressed in one frame → tick 1: PAUSE. Tick 2: single-step, mode+1.
- Reset/vsync: vsync low for 50 cycles → one frame_tick pulse of 1 cycle. Assert rst_n mid-BLANK → all outputs 0 immediately, mode=0.

Source files
------------

// File: rtl/vga_scene_sequencer_if.sv
// Bundles the signals between the sequencer, the hvsync generator, the buttons and the
// RGB pattern logic.
//   vsync                   : vertical sync from the hvsync generator (pixel-clock domain)
//   btn_next, btn_pause     : raw asynchronous push-buttons
//   speed[1:0], dir         : scroll step select and direction, sampled at the frame tick
//   scroll_x/y[9:0], mode   : pattern controls consumed by the RGB logic
//   blank, paused           : forced blanking and pause indication
//   frame_tick              : one-cycle pulse per frame
// Modport slave is the sequencer side; master is the surrounding system.
interface vga_scene_sequencer_if;
    logic       vsync;
    logic       btn_next;
    logic       btn_pause;
    logic [1:0] speed;
    logic       dir;
    logic [9:0] scroll_x;
    logic [9:0] scroll_y;
    logic [1:0] mode;
    logic       blank;
    logic       paused;
    logic       frame_tick;

    modport slave (
        input  vsync, btn_next, btn_pause, speed, dir,
        output scroll_x, scroll_y, mode, blank, paused, frame_tick
    );

    modport master (
        output vsync, btn_next, btn_pause, speed, dir,
        input  scroll_x, scroll_y, mode, blank, paused, frame_tick
    );
endinterface

// File: rtl/vga_scene_sequencer.sv
// Frame-synchronous scene controller for the VGA pattern datapath. Once per frame (on the
// inactive->active vsync edge) it updates scroll offsets, pattern mode and blanking. Scenes
// advance on a frame timer or a debounced button; a second button toggles pause, and in pause
// the next button single-steps the scene.
// Ports:
//   clk    : pixel clock, the only clock
//   rst_n  : asynchronous active-low reset
//   bus_io : sequencer side of vga_scene_sequencer_if (vsync, buttons, speed/dir in;
//            scroll_x/y, mode, blank, paused, frame_tick out)
module vga_scene_sequencer #(
    parameter int unsigned FRAMES_PER_SCENE = 256,
    parameter int unsigned BLANK_FRAMES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES  = 65536,
    parameter bit          VSYNC_ACTIVE     = 1'b0
) (
    input logic                  clk,
    input logic                  rst_n,
    vga_scene_sequencer_if.slave bus_io
);

    localparam int unsigned TimerW = $clog2(FRAMES_PER_SCENE);
    localparam int unsigned BcntW  = $clog2(BLANK_FRAMES + 1);
    localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {StRun, StBlank, StPause} state_e;

    state_e              state_q, state_d;
    logic                vsync_q;
    logic                frame_tick_q;
    logic [9:0]          scroll_x_q, scroll_x_d;
    logic [9:0]          scroll_y_q, scroll_y_d;
    logic [1:0]          mode_q, mode_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [BcntW-1:0]    bcnt_q, bcnt_d;
    logic                next_p_q, next_p_d;
    logic                pause_p_q, pause_p_d;

    // Button index 0 = next, 1 = pause.
    logic [1:0]          sync1_q, sync2_q;
    logic [1:0]          db_q, db_d;
    logic [1:0][DbW-1:0] db_cnt_q, db_cnt_d;
    logic [1:0]          rise;

    logic                tick;
    logic                timer_last;
    logic                bcnt_last;
    logic                new_scene;
    logic                next_clr;
    logic                pause_clr;
    logic [9:0]          step;

    assign tick       = (bus_io.vsync == VSYNC_ACTIVE) && (vsync_q != VSYNC_ACTIVE);
    assign timer_last = (timer_q == TimerW'(FRAMES_PER_SCENE - 1));
    assign bcnt_last  = (bcnt_q == BcntW'(BLANK_FRAMES - 1));
    assign step       = 10'd1 << bus_io.speed;

    // Debounce: the level flips on the DEBOUNCE_CYCLES-th consecutive differing cycle.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DbW'(DEBOUNCE_CYCLES - 1)) begin
                    db_d[i] = ~db_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
                end
            end
        end
    end

    assign rise = db_d & ~db_q;

    // State register and all datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StRun;
            vsync_q      <= 1'b0;
            frame_tick_q <= 1'b0;
            scroll_x_q   <= '0;
            scroll_y_q   <= '0;
            mode_q       <= '0;
            timer_q      <= '0;
            bcnt_q       <= '0;
            next_p_q     <= 1'b0;
            pause_p_q    <= 1'b0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            db_q         <= '0;
            db_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= bus_io.vsync;
            frame_tick_q <= tick;
            scroll_x_q   <= scroll_x_d;
            scroll_y_q   <= scroll_y_d;
            mode_q       <= mode_d;
            timer_q      <= timer_d;
            bcnt_q       <= bcnt_d;
            next_p_q     <= next_p_d;
            pause_p_q    <= pause_p_d;
            sync1_q      <= {bus_io.btn_pause, bus_io.btn_next};
            sync2_q      <= sync1_q;
            db_q         <= db_d;
            db_cnt_q     <= db_cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (tick) begin
            unique case (state_q)
                StRun: begin
                    if (pause_p_q) begin
                        state_d = StPause;
                    end else if (next_p_q || timer_last) begin
                        state_d = StBlank;
                    end
                end
                StBlank: if (bcnt_last) state_d = StRun;
                StPause: if (pause_p_q) state_d = StRun;
                default: state_d = StRun;
            endcase
        end
    end

    // Datapath updates, all qualified by the frame tick.
    always_comb begin
        scroll_x_d = scroll_x_q;
        scroll_y_d = scroll_y_q;
        mode_d     = mode_q;
        timer_d    = timer_q;
        bcnt_d     = bcnt_q;
        new_scene  = 1'b0;
        next_clr   = 1'b0;
        pause_clr  = 1'b0;
        if (tick) begin
            unique case (state_q)
                StRun: begin
                    if (pause_p_q) begin
                        pause_clr = 1'b1;
                    end else if (next_p_q || timer_last) begin
                        timer_d  = '0;
                        bcnt_d   = '0;
                        next_clr = 1'b1;
                    end else begin
                        timer_d    = timer_q + TimerW'(1);
                        scroll_x_d = bus_io.dir ? (scroll_x_q - step) : (scroll_x_q + step);
                        if (mode_q[1]) scroll_y_d = scroll_y_q + 10'd1;
                    end
                end
                StBlank: begin
                    // Presses during blanking are discarded.
                    next_clr = 1'b1;
                    if (bcnt_last) begin
                        new_scene = 1'b1;
                    end else begin
                        bcnt_d = bcnt_q + BcntW'(1);
                    end
                end
                StPause: begin
                    if (pause_p_q) begin
                        pause_clr = 1'b1;
                    end else if (next_p_q) begin
                        next_clr  = 1'b1;
                        new_scene = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (new_scene) begin
            mode_d     = mode_q + 2'd1;
            scroll_x_d = '0;
            scroll_y_d = '0;
            timer_d    = '0;
        end
        // A fresh press on the consuming edge is kept rather than lost.
        next_p_d  = (next_p_q & ~next_clr) | rise[0];
        pause_p_d = (pause_p_q & ~pause_clr) | rise[1];
    end

    // Outputs.
    always_comb begin
        bus_io.scroll_x   = scroll_x_q;
        bus_io.scroll_y   = scroll_y_q;
        bus_io.mode       = mode_q;
        bus_io.frame_tick = frame_tick_q;
        bus_io.blank      = (state_q == StBlank);
        bus_io.paused     = (state_q == StPause);
    end

endmodule

// File: tb/tb_vga_scene_sequencer.sv
// Self-checking bench for vga_scene_sequencer: a table of directed frames, hand-written
// debounce / pause / reset sequences, then randomized frames against a reference model.
module tb_vga_scene_sequencer;

    localparam int FPS = 4;
    localparam int BF  = 2;
    localparam int DEB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    vga_scene_sequencer_if bus();

    vga_scene_sequencer #(
        .FRAMES_PER_SCENE(FPS),
        .BLANK_FRAMES    (BF),
        .DEBOUNCE_CYCLES (DEB),
        .VSYNC_ACTIVE    (1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_io(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int speed;
        int dir;
        int sx;
        int sy;
        int mode;
        int blank;
    } vec_t;

    vec_t vec[18];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a scene is "frames shown so far"; blanking is a countdown.
    int m_sx, m_sy, m_mode, m_frame, m_blank_left;
    bit m_paused, m_np, m_pp;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sx = 0; m_sy = 0; m_mode = 0; m_frame = 0; m_blank_left = 0;
        m_paused = 0; m_np = 0; m_pp = 0;
    endtask

    task automatic model_new_scene();
        m_mode  = (m_mode + 1) % 4;
        m_sx    = 0;
        m_sy    = 0;
        m_frame = 0;
    endtask

    task automatic model_tick();
        int step;
        step = 1 << int'(bus.speed);
        if (m_paused) begin
            if (m_pp) begin
                m_pp = 0; m_paused = 0;
            end else if (m_np) begin
                m_np = 0; model_new_scene();
            end
        end else if (m_blank_left > 0) begin
            m_np = 0;
            m_blank_left--;
            if (m_blank_left == 0) model_new_scene();
        end else if (m_pp) begin
            m_pp = 0; m_paused = 1;
        end else if (m_np || m_frame == FPS - 1) begin
            m_np = 0; m_blank_left = BF; m_frame = 0;
        end else begin
            m_frame++;
            m_sx = (m_sx + (bus.dir ? 1024 - step : step)) % 1024;
            if (m_mode >= 2) m_sy = (m_sy + 1) % 1024;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".scroll_x"}, int'(bus.scroll_x), m_sx);
        check({tag, ".scroll_y"}, int'(bus.scroll_y), m_sy);
        check({tag, ".mode"},     int'(bus.mode),     m_mode);
        check({tag, ".blank"},    int'(bus.blank),    (m_blank_left > 0) ? 1 : 0);
        check({tag, ".paused"},   int'(bus.paused),   int'(m_paused));
    endtask

    // One vsync pulse held active for low_cycles clocks, then a short inactive gap.
    task automatic frame(input string tag, input int low_cycles);
        int pulses;
        @(negedge clk);
        bus.vsync = 1'b0;
        @(posedge clk);
        model_tick();
        @(negedge clk);
        check({tag, ".frame_tick"}, int'(bus.frame_tick), 1);
        check_model(tag);
        pulses = 1;
        for (int i = 1; i < low_cycles; i++) begin
            @(negedge clk);
            pulses += int'(bus.frame_tick);
        end
        bus.vsync = 1'b1;
        repeat (3) begin
            @(negedge clk);
            pulses += int'(bus.frame_tick);
        end
        check({tag, ".tick_pulses"}, pulses, 1);
    endtask

    // Hold buttons for `hold` clocks, release, and let both debounce edges settle.
    task automatic press(input bit nx, input bit ps, input int hold);
        @(negedge clk);
        bus.btn_next  = nx;
        bus.btn_pause = ps;
        repeat (hold) @(negedge clk);
        bus.btn_next  = 1'b0;
        bus.btn_pause = 1'b0;
        repeat (12) @(negedge clk);
        if (hold >= DEB) begin
            if (nx) m_np = 1;
            if (ps) m_pp = 1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".scroll_x"},   int'(bus.scroll_x),   0);
        check({tag, ".scroll_y"},   int'(bus.scroll_y),   0);
        check({tag, ".mode"},       int'(bus.mode),       0);
        check({tag, ".blank"},      int'(bus.blank),      0);
        check({tag, ".paused"},     int'(bus.paused),     0);
        check({tag, ".frame_tick"}, int'(bus.frame_tick), 0);
    endtask

    initial begin
        int pulses;
        int r;
        int sx_hold;

        vec[0]  = '{1, 0,    2, 0, 0, 0};
        vec[1]  = '{1, 0,    4, 0, 0, 0};
        vec[2]  = '{1, 0,    6, 0, 0, 0};
        vec[3]  = '{1, 0,    6, 0, 0, 1};
        vec[4]  = '{1, 0,    6, 0, 0, 1};
        vec[5]  = '{1, 0,    0, 0, 1, 0};
        vec[6]  = '{3, 1, 1016, 0, 1, 0};
        vec[7]  = '{3, 1, 1008, 0, 1, 0};
        vec[8]  = '{3, 1, 1000, 0, 1, 0};
        vec[9]  = '{3, 1, 1000, 0, 1, 1};
        vec[10] = '{3, 1, 1000, 0, 1, 1};
        vec[11] = '{3, 1,    0, 0, 2, 0};
        vec[12] = '{0, 0,    1, 1, 2, 0};
        vec[13] = '{0, 0,    2, 2, 2, 0};
        vec[14] = '{0, 0,    3, 3, 2, 0};
        vec[15] = '{0, 0,    3, 3, 2, 1};
        vec[16] = '{0, 0,    3, 3, 2, 1};
        vec[17] = '{0, 0,    0, 0, 3, 0};

        bus.vsync     = 1'b1;
        bus.btn_next  = 1'b0;
        bus.btn_pause = 1'b0;
        bus.speed     = 2'd0;
        bus.dir       = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Directed table: auto advance, wrap-around subtract, scroll_y in mode 2.
        for (int i = 0; i < 18; i++) begin
            bus.speed = 2'(vec[i].speed);
            bus.dir   = 1'(vec[i].dir);
            frame($sformatf("tbl%0d", i), 2);
            check("tbl.scroll_x", int'(bus.scroll_x), vec[i].sx);
            check("tbl.scroll_y", int'(bus.scroll_y), vec[i].sy);
            check("tbl.mode",     int'(bus.mode),     vec[i].mode);
            check("tbl.blank",    int'(bus.blank),    vec[i].blank);
        end

        // Debounce: a 3-cycle glitch is ignored, a 10-cycle press enters blanking.
        bus.speed = 2'd0;
        bus.dir   = 1'b0;
        press(1'b1, 1'b0, 3);
        frame("glitch", 2);
        check("glitch.blank", int'(bus.blank), 0);
        press(1'b1, 1'b0, 10);
        frame("next_press", 2);
        check("next_press.blank", int'(bus.blank), 1);
        press(1'b1, 1'b0, 10);
        frame("blank_press", 2);
        frame("blank_end", 2);
        check("blank_end.mode", int'(bus.mode), 0);
        frame("after_blank", 2);
        check("after_blank.blank", int'(bus.blank), 0);

        // Pause, frozen frames, single step, resume.
        bus.speed = 2'd2;
        press(1'b0, 1'b1, 10);
        frame("pause", 2);
        check("pause.paused", int'(bus.paused), 1);
        sx_hold = int'(bus.scroll_x);
        for (int i = 0; i < 3; i++) frame("frozen", 2);
        check("frozen.scroll_x", int'(bus.scroll_x), sx_hold);
        press(1'b1, 1'b0, 10);
        frame("step", 2);
        check("step.scroll_x", int'(bus.scroll_x), 0);
        check("step.paused",   int'(bus.paused),   1);
        press(1'b0, 1'b1, 10);
        frame("resume", 2);
        frame("resume_run", 2);
        check("resume_run.scroll_x", int'(bus.scroll_x), 4);

        // Both buttons in one frame: pause first, then a single step.
        press(1'b1, 1'b1, 10);
        frame("both1", 2);
        frame("both2", 2);
        press(1'b0, 1'b1, 10);
        frame("both_resume", 2);

        // Long vsync still gives one tick.
        frame("long_vsync", 50);

        // Reset during blanking acts immediately.
        press(1'b1, 1'b0, 10);
        frame("pre_reset", 2);
        check("pre_reset.blank", int'(bus.blank), 1);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        model_reset();
        // Vsync already active at release must not tick.
        bus.vsync = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            pulses += int'(bus.frame_tick);
        end
        check("no_tick_after_reset", pulses, 0);
        bus.vsync = 1'b1;
        repeat (2) @(negedge clk);

        // Randomized frames against the reference model.
        for (int i = 0; i < 120; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 12)      press(1'b1, 1'b0, int'($urandom_range(5, 10)));
            else if (r < 22) press(1'b0, 1'b1, int'($urandom_range(5, 10)));
            else if (r < 26) press(1'b1, 1'b1, int'($urandom_range(5, 10)));
            else if (r < 32) press(1'($urandom_range(0, 1)), 1'b0, int'($urandom_range(1, 3)));
            bus.speed = 2'($urandom_range(0, 3));
            bus.dir   = 1'($urandom_range(0, 1));
            frame("rand", int'($urandom_range(1, 6)));
            // Changes between ticks must have no effect.
            bus.speed = 2'($urandom_range(0, 3));
            bus.dir   = 1'($urandom_range(0, 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
